// File: rtl/snake_cmd_tile_writer.sv
// Draw-command consumer for the snake core: buffers 32-bit commands, writes logical cells
// (point / rect fill) into the tile colour RAM and forwards physical-pixel opcodes downstream.
module snake_cmd_tile_writer #(
  parameter int CMD_WIDTH      = 32,
  parameter int H_LOGIC_WIDTH  = 5,
  parameter int V_LOGIC_WIDTH  = 5,
  parameter int H_LOGIC_MAX    = 31,
  parameter int V_LOGIC_MAX    = 23,
  parameter int COLOR_ID_WIDTH = 8,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CMD_WIDTH-1:0]                   cmd,
  input  logic                                   cmd_vld,
  output logic                                   wr_en,
  output logic [V_LOGIC_WIDTH+H_LOGIC_WIDTH-1:0] wr_addr,
  output logic [COLOR_ID_WIDTH-1:0]              wr_data,
  output logic [CMD_WIDTH-1:0]                   phy_cmd,
  output logic                                   phy_cmd_vld,
  input  logic                                   phy_cmd_rdy,
  output logic                                   busy,
  output logic                                   overflow,
  output logic [7:0]                             drop_cnt,
  output logic [2:0]                             dbg_state
);

  localparam int HW = H_LOGIC_WIDTH;
  localparam int VW = V_LOGIC_WIDTH;
  localparam int CW = COLOR_ID_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int F0 = CMD_WIDTH - 5;  // top bit of the first payload field
  localparam logic [HW-1:0] H_MAX_L = H_LOGIC_MAX[HW-1:0];
  localparam logic [VW-1:0] V_MAX_L = V_LOGIC_MAX[VW-1:0];

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_POINT = 3'd2,
    S_RECT  = 3'd3,
    S_FWD   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // FIFO with one extra pointer bit to tell full from empty.
  logic [CMD_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW:0]          wr_ptr_q, rd_ptr_q;
  logic                 fifo_empty, fifo_full, pop, push, push_drop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign push       = cmd_vld && (!fifo_full || pop);
  assign push_drop  = cmd_vld && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= cmd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  logic [CMD_WIDTH-1:0] cur_cmd_q, cur_cmd_d;
  logic [HW-1:0]        cx_q, cx_d, x0_q, x0_d, x1_q, x1_d;
  logic [VW-1:0]        cy_q, cy_d, y1_q, y1_d;
  logic [CW-1:0]        col_q, col_d;
  logic                 wr_en_q, wr_en_d, phy_vld_q, phy_vld_d, overflow_q, overflow_d;
  logic [VW+HW-1:0]     wr_addr_q, wr_addr_d;
  logic [CW-1:0]        wr_data_q, wr_data_d;
  logic [CMD_WIDTH-1:0] phy_cmd_q, phy_cmd_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;
  logic                 fsm_drop;

  // Field decode of the command currently held by the FSM.
  logic [3:0]    op;
  logic [HW-1:0] px, rx1, rx1_c;
  logic [VW-1:0] py, ry1, ry1_c;
  logic [CW-1:0] pcol, rcol;
  logic          rect_empty, reserved_op;

  assign op          = cur_cmd_q[CMD_WIDTH-1 -: 4];
  assign px          = cur_cmd_q[F0 -: HW];
  assign py          = cur_cmd_q[F0-HW -: VW];
  assign pcol        = cur_cmd_q[F0-HW-VW -: CW];
  assign rx1         = cur_cmd_q[F0-HW-VW -: HW];
  assign ry1         = cur_cmd_q[F0-2*HW-VW -: VW];
  assign rcol        = cur_cmd_q[CW-1:0];
  assign rx1_c       = (rx1 > H_MAX_L) ? H_MAX_L : rx1;
  assign ry1_c       = (ry1 > V_MAX_L) ? V_MAX_L : ry1;
  assign rect_empty  = (px > rx1_c) || (py > ry1_c);
  assign reserved_op = !op[3] && (op > 4'd1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_LOAD;
      S_LOAD: begin
        if (op[3])               state_d = S_FWD;
        else if (op == 4'd0)     state_d = S_POINT;
        else if (op == 4'd1)     state_d = rect_empty ? S_IDLE : S_RECT;
        else                     state_d = S_IDLE;
      end
      S_POINT: state_d = S_IDLE;
      S_RECT:  if ((cx_q == x1_q) && (cy_q == y1_q)) state_d = S_IDLE;
      S_FWD:   if (phy_vld_q && phy_cmd_rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cur_cmd_d = pop ? fifo_mem[rd_ptr_q[PW-1:0]] : cur_cmd_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    col_d     = col_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    phy_vld_d = 1'b0;
    phy_cmd_d = phy_cmd_q;
    fsm_drop  = 1'b0;
    case (state_q)
      S_LOAD: begin
        cx_d     = px;
        cy_d     = py;
        x0_d     = px;
        x1_d     = rx1_c;
        y1_d     = ry1_c;
        col_d    = rcol;
        fsm_drop = reserved_op;
      end
      S_POINT: begin
        if (py <= V_MAX_L) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {py, px};
          wr_data_d = pcol;
        end else begin
          fsm_drop = 1'b1;
        end
      end
      S_RECT: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {cy_q, cx_q};
        wr_data_d = col_q;
        if (cx_q == x1_q) begin
          cx_d = x0_q;
          if (cy_q != y1_q) cy_d = cy_q + 1'b1;
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      S_FWD: begin
        phy_cmd_d = cur_cmd_q;
        phy_vld_d = !(phy_vld_q && phy_cmd_rdy);
      end
      default: ;
    endcase
  end

  // A FIFO overflow and an FSM discard can land in the same cycle, so the step can be 2.
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;
  assign drop_inc   = {1'b0, push_drop} + {1'b0, fsm_drop};
  assign drop_sum   = {1'b0, drop_cnt_q} + {7'b0, drop_inc};
  assign drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  assign overflow_d = overflow_q | push_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_cmd_q  <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      col_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      phy_vld_q  <= 1'b0;
      phy_cmd_q  <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      cur_cmd_q  <= cur_cmd_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      col_q      <= col_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      phy_vld_q  <= phy_vld_d;
      phy_cmd_q  <= phy_cmd_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign phy_cmd     = phy_cmd_q;
  assign phy_cmd_vld = phy_vld_q;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;
  assign busy        = !fifo_empty || (state_q != S_IDLE) || wr_en_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_snake_cmd_tile_writer.sv
// Directed bench for snake_cmd_tile_writer: points, rect fills, FIFO overflow, forwarding, reset abort.
module tb_snake_cmd_tile_writer;

  logic        clk, rst;
  logic [31:0] cmd;
  logic        cmd_vld;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [31:0] phy_cmd;
  logic        phy_cmd_vld, phy_cmd_rdy;
  logic        busy, overflow;
  logic [7:0]  drop_cnt;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [17:0] wr_q[$];
  int          cyc_q[$];

  snake_cmd_tile_writer dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd),
    .cmd_vld     (cmd_vld),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .phy_cmd     (phy_cmd),
    .phy_cmd_vld (phy_cmd_vld),
    .phy_cmd_rdy (phy_cmd_rdy),
    .busy        (busy),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt),
    .dbg_state   (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Write monitor: logs {addr, data} of every tile write.
  always @(negedge clk) begin
    #1;
    if (wr_en === 1'b1) begin
      wr_q.push_back({wr_addr, wr_data});
      cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pt(input logic [4:0] x, input logic [4:0] y, input logic [7:0] c);
    return {4'h0, x, y, c, 10'd0};
  endfunction

  function automatic logic [31:0] rc(input logic [4:0] x0, input logic [4:0] y0,
                                     input logic [4:0] x1, input logic [4:0] y1, input logic [7:0] c);
    return {4'h1, x0, y0, x1, y1, c};
  endfunction

  // Presents one command for exactly one rising edge; returns at the following negedge.
  task automatic send(input logic [31:0] c);
    cmd     = c;
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int t = 0;
    while (busy && t < lim) begin
      @(negedge clk);
      t++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
    #2;
  endtask

  initial begin
    int bad;
    int n;
    int t;
    logic [17:0] e;

    rst = 1'b1; cmd = '0; cmd_vld = 1'b0; phy_cmd_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_phy_vld", {31'd0, phy_cmd_vld}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // T1: single point, write visible after the fourth edge counting the sampling edge.
    wr_q.delete();
    send(pt(5'd5, 5'd7, 8'h0F));
    @(negedge clk); chk("t1_lat1", {31'd0, wr_en}, 32'd0);
    @(negedge clk); chk("t1_lat2", {31'd0, wr_en}, 32'd0);
    @(negedge clk);
    chk("t1_wr_en", {31'd0, wr_en}, 32'd1);
    chk("t1_addr", {22'd0, wr_addr}, 32'h0E5);
    chk("t1_data", {24'd0, wr_data}, 32'h0F);
    @(negedge clk); chk("t1_single", {31'd0, wr_en}, 32'd0);
    wait_idle("t1_idle", 50);
    chk("t1_count", wr_q.size(), 32'd1);

    // T2 + T3: full-screen clear with 10 points queued behind it.
    wr_q.delete(); cyc_q.delete();
    send(rc(5'd0, 5'd0, 5'd31, 5'd23, 8'hFF));
    for (int i = 0; i < 10; i++) send(pt(5'(i + 1), 5'd2, 8'(8'h10 + i)));
    chk("t3_no_overflow_mid", {31'd0, overflow}, 32'd0);
    wait_idle("t2_idle", 2000);
    chk("t2_count", wr_q.size(), 32'd778);
    bad = 0;
    for (int i = 0; i < 768; i++)
      if (i >= wr_q.size() || wr_q[i] !== {10'(i), 8'hFF}) bad++;
    chk("t2_rect_cells", bad, 32'd0);
    chk("t2_contiguous", (cyc_q.size() >= 768) ? (cyc_q[767] - cyc_q[0]) : -1, 32'd767);
    for (int i = 0; i < 10; i++) begin
      e = {5'd2, 5'(i + 1), 8'(8'h10 + i)};
      chk($sformatf("t3_point%0d", i), (768 + i < wr_q.size()) ? {14'd0, wr_q[768 + i]} : 32'hDEAD, {14'd0, e});
    end
    chk("t3_overflow", {31'd0, overflow}, 32'd0);
    chk("t3_drop_cnt", {24'd0, drop_cnt}, 32'd0);

    // T4: 17 commands while the rect holds the FSM; the 17th is dropped.
    wr_q.delete();
    send(rc(5'd0, 5'd0, 5'd31, 5'd23, 8'hFF));
    repeat (3) @(negedge clk);
    for (int i = 0; i < 17; i++) send(pt(5'(i), 5'd3, 8'(8'h40 + i)));
    chk("t4_overflow_now", {31'd0, overflow}, 32'd1);
    wait_idle("t4_idle", 2000);
    chk("t4_count", wr_q.size(), 32'd784);
    for (int i = 0; i < 16; i++) begin
      e = {5'd3, 5'(i), 8'(8'h40 + i)};
      chk($sformatf("t4_point%0d", i), (768 + i < wr_q.size()) ? {14'd0, wr_q[768 + i]} : 32'hDEAD, {14'd0, e});
    end
    chk("t4_overflow", {31'd0, overflow}, 32'd1);
    chk("t4_drop_cnt", {24'd0, drop_cnt}, 32'd1);

    // T5: forwarded physical command held while downstream stalls.
    wr_q.delete();
    send(32'h9ABC_DEF1);
    @(negedge clk); chk("t5_lat1", {31'd0, phy_cmd_vld}, 32'd0);
    @(negedge clk); chk("t5_lat2", {31'd0, phy_cmd_vld}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t5_vld%0d", i), {31'd0, phy_cmd_vld}, 32'd1);
      chk($sformatf("t5_cmd%0d", i), phy_cmd, 32'h9ABC_DEF1);
    end
    phy_cmd_rdy = 1'b1;
    @(negedge clk);
    phy_cmd_rdy = 1'b0;
    chk("t5_released", {31'd0, phy_cmd_vld}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    #2;
    chk("t5_no_writes", wr_q.size(), 32'd0);

    // T6: reset on the 100th write of a clear aborts it.
    wr_q.delete();
    send(rc(5'd0, 5'd0, 5'd31, 5'd23, 8'hFF));
    n = 0; t = 0;
    while (n < 100 && t < 2000) begin
      @(negedge clk);
      t++;
      if (wr_en === 1'b1) n++;
    end
    chk("t6_reached_100", n, 32'd100);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_wr_en", {31'd0, wr_en}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_overflow_clr", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    chk("t6_no_more_writes", wr_q.size(), 32'd100);
    chk("t6_still_idle", {31'd0, busy}, 32'd0);
    chk("t6_drop_clr", {24'd0, drop_cnt}, 32'd0);

    wr_q.delete();
    send(pt(5'd31, 5'd23, 8'hAA));
    wait_idle("t6_pt_idle", 50);
    chk("t6_pt_count", wr_q.size(), 32'd1);
    chk("t6_pt_entry", (wr_q.size() > 0) ? {14'd0, wr_q[0]} : 32'hDEAD, {14'd0, 10'h2FF, 8'hAA});

    // Inverted rect writes nothing.
    wr_q.delete();
    send(rc(5'd10, 5'd0, 5'd3, 5'd5, 8'h55));
    wait_idle("inv_idle", 50);
    chk("inv_count", wr_q.size(), 32'd0);
    chk("inv_drop_cnt", {24'd0, drop_cnt}, 32'd0);

    // y1 beyond the last row is clamped to 23.
    wr_q.delete();
    send(rc(5'd30, 5'd22, 5'd31, 5'd31, 8'h77));
    wait_idle("clamp_idle", 50);
    chk("clamp_count", wr_q.size(), 32'd4);
    chk("clamp_c0", (wr_q.size() > 0) ? {14'd0, wr_q[0]} : 32'hDEAD, {14'd0, 10'h2DE, 8'h77});
    chk("clamp_c1", (wr_q.size() > 1) ? {14'd0, wr_q[1]} : 32'hDEAD, {14'd0, 10'h2DF, 8'h77});
    chk("clamp_c2", (wr_q.size() > 2) ? {14'd0, wr_q[2]} : 32'hDEAD, {14'd0, 10'h2FE, 8'h77});
    chk("clamp_c3", (wr_q.size() > 3) ? {14'd0, wr_q[3]} : 32'hDEAD, {14'd0, 10'h2FF, 8'h77});

    // Point below the last row: discarded and counted.
    wr_q.delete();
    send(pt(5'd1, 5'd24, 8'h11));
    wait_idle("ybad_idle", 50);
    chk("ybad_count", wr_q.size(), 32'd0);
    chk("ybad_drop_cnt", {24'd0, drop_cnt}, 32'd1);

    // Reserved opcode 3: discarded and counted.
    send(32'h3123_4567);
    wait_idle("op3_idle", 50);
    chk("op3_count", wr_q.size(), 32'd0);
    chk("op3_drop_cnt", {24'd0, drop_cnt}, 32'd2);
    chk("op3_no_phy", {31'd0, phy_cmd_vld}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
